sram_arb2_ctrl: RTL
===================

// Module: sram_arb2_ctrl
// PURPOSE
// - Two-requester round-robin arbiter/sequencer for one single-port SRAM22 macro (64x32, 8-bit wmask).
// - Each requester has a valid/ready command channel and a non-stallable read-response channel.
// - Registers the winning command onto the macro pins and returns read data to the owning requester.
// - Sits between the SoC-side masters and the macro; the macro shares clk with this block.
// PARAMETERS
// - DATA_WIDTH   32  data bits per word
// - ADDR_WIDTH   6   word address bits
// - WMASK_WIDTH  4   byte-lane write mask bits (DATA_WIDTH/8)
// PORTS
// - clk          in   1    clock, shared with the SRAM macro
// - rst_n        in   1    asynchronous active-low reset
// - a_valid      in   1    requester A command valid
// - a_ready      out  1    requester A command accepted this cycle
// - a_we         in   1    A write enable (1=write, 0=read)
// - a_wmask      in   WMASK_WIDTH  A byte mask
// - a_addr       in   ADDR_WIDTH   A word address
// - a_din        in   DATA_WIDTH   A write data
// - a_rvalid     out  1    A read data valid
// - a_rdata      out  DATA_WIDTH   A read data
// - b_*          same set as a_* for requester B
// - sram_we      out  1    to macro we
// - sram_wmask   out  WMASK_WIDTH  to macro wmask
// - sram_addr    out  ADDR_WIDTH   to macro addr
// - sram_din     out  DATA_WIDTH   to macro din
// - sram_dout    in   DATA_WIDTH   from macro dout
// BEHAVIOUR
// - Accept = x_valid & x_ready at a rising edge (E0). At most one accept per cycle; x_ready is
//   combinational from x_valid and the priority pointer, never depends on x_ready of the other side.
// - Arbitration: only one valid -> it wins. Both valid -> pointer side wins; after each accept the
//   pointer moves to the loser side. Pointer resets to A.
// - Command stage: at E0 sram_we/wmask/addr/din load the winner's fields; with no accept, sram_we and
//   sram_wmask load 0 (idle read of last addr; result discarded). Macro samples at E1.
// - Read response: owner tag + read flag pipelined 2 stages; x_rvalid high for exactly one cycle
//   after E1 (2 cycles after accept), x_rdata = sram_dout combinationally in that cycle, else 0.
// - Writes produce no response; macro dout during write cycle is X and must never reach x_rdata.
// - Throughput: one access per cycle sustained; back-to-back reads from same requester give
//   back-to-back x_rvalid. No response backpressure; requesters must sink rvalid.
// - Write with wmask=0 consumes a slot, changes no memory.
// - Read after write to same addr by either requester: ordering is issue order; read accepted the
//   cycle after the write returns the new data (macro completes write at its edge).
// - Reset (async assert): a_ready/b_ready=0 while rst_n low, all outputs 0, sram_we=0, pointer=A,
//   in-flight reads dropped (no rvalid after deassert). Release is sampled synchronously.
// CONFIGURATION
// - SRAM_ARB_CONFLICT_CNT_EN defined: adds ports conflict_clr (in,1) and conflict_cnt (out,16).
//   conflict_cnt increments on each cycle with a_valid & b_valid, saturates at 16'hFFFF,
//   sync-clears on conflict_clr (clear wins over increment), resets to 0.
// - Not defined: ports absent, no counter logic; arbitration behaviour identical.
// TESTING
// - Reset: rst_n low mid-read -> no a_rvalid/b_rvalid after release, sram_we=0, a_ready=b_ready=0 low.
// - A writes addr 5 din 32'hDEADBEEF wmask 4'hF, then A reads 5 -> a_rvalid 2 cycles after accept,
//   a_rdata=32'hDEADBEEF, b_rvalid stays 0.
// - Byte mask: write 32'h11223344 all lanes, then 32'hAABBCCDD wmask 4'b0101 -> read 32'h11BB33DD.
// - Contention: a_valid=b_valid=1 reads for 4 cycles -> grants A,B,A,B; responses alternate to owner.
// - Single requester B streaming 8 reads addr 0..7 -> b_ready held 1, 8 consecutive b_rvalid in order.
// - With SRAM_ARB_CONFLICT_CNT_EN: 3 conflict cycles -> conflict_cnt=3; conflict_clr + conflict same
//   cycle -> 0.

Source files
------------

// File: rtl/sram_arb2_ctrl_if.sv
// rtl/sram_arb2_ctrl_if.sv - requester command/response and SRAM macro pin bundle for sram_arb2_ctrl
interface sram_arb2_ctrl_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 4
);
  logic                   a_valid;
  logic                   a_ready;
  logic                   a_we;
  logic [WMASK_WIDTH-1:0] a_wmask;
  logic [ADDR_WIDTH-1:0]  a_addr;
  logic [DATA_WIDTH-1:0]  a_din;
  logic                   a_rvalid;
  logic [DATA_WIDTH-1:0]  a_rdata;

  logic                   b_valid;
  logic                   b_ready;
  logic                   b_we;
  logic [WMASK_WIDTH-1:0] b_wmask;
  logic [ADDR_WIDTH-1:0]  b_addr;
  logic [DATA_WIDTH-1:0]  b_din;
  logic                   b_rvalid;
  logic [DATA_WIDTH-1:0]  b_rdata;

  logic                   sram_we;
  logic [WMASK_WIDTH-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0]  sram_addr;
  logic [DATA_WIDTH-1:0]  sram_din;
  logic [DATA_WIDTH-1:0]  sram_dout;

  modport slave (
    input  a_valid, a_we, a_wmask, a_addr, a_din,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_we, b_wmask, b_addr, b_din,
    output b_ready, b_rvalid, b_rdata,
    output sram_we, sram_wmask, sram_addr, sram_din,
    input  sram_dout
  );

  modport master (
    output a_valid, a_we, a_wmask, a_addr, a_din,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_we, b_wmask, b_addr, b_din,
    input  b_ready, b_rvalid, b_rdata,
    input  sram_we, sram_wmask, sram_addr, sram_din,
    output sram_dout
  );
endinterface

// File: rtl/sram_arb2_ctrl.sv
// rtl/sram_arb2_ctrl.sv - two-requester round-robin arbiter/sequencer for one single-port SRAM macro
// Optional conflict counter ports enabled by SRAM_ARB_CONFLICT_CNT_EN.
module sram_arb2_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef SRAM_ARB_CONFLICT_CNT_EN
  input  logic                   conflict_clr,
  output logic [15:0]            conflict_cnt,
`endif
  sram_arb2_ctrl_if.slave        bus
);

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

  ptr_e                   ptr_q, ptr_d;
  logic                   grant_a, grant_b;

  logic                   sram_we_q, sram_we_d;
  logic [WMASK_WIDTH-1:0] sram_wmask_q, sram_wmask_d;
  logic [ADDR_WIDTH-1:0]  sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0]  sram_din_q, sram_din_d;

  logic                   rd1_vld_q, rd1_vld_d;
  logic                   rd1_own_q, rd1_own_d;
  logic                   rd2_vld_q;
  logic                   rd2_own_q;
  logic                   a_rvalid, b_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Grants are gated by rst_n so ready reads low for the whole reset window.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    ptr_d   = ptr_q;
    if (rst_n) begin
      if (bus.a_valid && (!bus.b_valid || ptr_q == PTR_A)) begin
        grant_a = 1'b1;
      end else if (bus.b_valid) begin
        grant_b = 1'b1;
      end
    end
    if (grant_a) begin
      ptr_d = PTR_B;
    end else if (grant_b) begin
      ptr_d = PTR_A;
    end
  end

  // Idle cycles issue a harmless read of the last address; its result is never tagged.
  always_comb begin
    sram_we_d    = 1'b0;
    sram_wmask_d = '0;
    sram_addr_d  = sram_addr_q;
    sram_din_d   = sram_din_q;
    rd1_vld_d    = 1'b0;
    rd1_own_d    = grant_b;
    if (grant_a) begin
      sram_we_d    = bus.a_we;
      sram_wmask_d = bus.a_wmask;
      sram_addr_d  = bus.a_addr;
      sram_din_d   = bus.a_din;
      rd1_vld_d    = ~bus.a_we;
    end else if (grant_b) begin
      sram_we_d    = bus.b_we;
      sram_wmask_d = bus.b_wmask;
      sram_addr_d  = bus.b_addr;
      sram_din_d   = bus.b_din;
      rd1_vld_d    = ~bus.b_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_we_q    <= 1'b0;
      sram_wmask_q <= '0;
      sram_addr_q  <= '0;
      sram_din_q   <= '0;
      rd1_vld_q    <= 1'b0;
      rd1_own_q    <= 1'b0;
      rd2_vld_q    <= 1'b0;
      rd2_own_q    <= 1'b0;
    end else begin
      sram_we_q    <= sram_we_d;
      sram_wmask_q <= sram_wmask_d;
      sram_addr_q  <= sram_addr_d;
      sram_din_q   <= sram_din_d;
      rd1_vld_q    <= rd1_vld_d;
      rd1_own_q    <= rd1_own_d;
      rd2_vld_q    <= rd1_vld_q;
      rd2_own_q    <= rd1_own_q;
    end
  end

  assign a_rvalid = rd2_vld_q & ~rd2_own_q;
  assign b_rvalid = rd2_vld_q &  rd2_own_q;

  assign bus.a_ready    = grant_a;
  assign bus.b_ready    = grant_b;
  assign bus.a_rvalid   = a_rvalid;
  assign bus.b_rvalid   = b_rvalid;
  // Macro dout is undefined on write cycles, so data is only passed while a response is due.
  assign bus.a_rdata    = a_rvalid ? bus.sram_dout : '0;
  assign bus.b_rdata    = b_rvalid ? bus.sram_dout : '0;
  assign bus.sram_we    = sram_we_q;
  assign bus.sram_wmask = sram_wmask_q;
  assign bus.sram_addr  = sram_addr_q;
  assign bus.sram_din   = sram_din_q;

`ifdef SRAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict_clr) begin
      conflict_cnt_d = '0;
    end else if (bus.a_valid && bus.b_valid && conflict_cnt_q != 16'hFFFF) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
